// File: rtl/aoi5_pkg.sv
// aoi5_pkg: shared state encoding, sweep constants and the golden AOI5 function. Rev 1.0
`default_nettype none

package aoi5_pkg;

  localparam int NUM_VEC = 32;
  localparam int VEC_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // vec = {a, b, c, d, e}
  function automatic logic aoi5_ref(input logic [VEC_W-1:0] v);
    return ~((v[4] | ~v[3]) & ((v[2] & v[1]) | v[0]));
  endfunction

endpackage

`default_nettype wire

// File: rtl/aoi5_settle_timer.sv
// aoi5_settle_timer: 4-bit down-counter loaded with SETTLE, flags the last DRIVE cycle. Rev 1.0
`default_nettype none

module aoi5_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(SETTLE);
    end else if (en && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = en && (cnt == 4'd1);

endmodule

`default_nettype wire

// File: rtl/aoi5_sweep_ctrl.sv
// aoi5_sweep_ctrl: exhaustive 32-vector sweep of an external AOI5 unit into a truth table.
// Optional golden compare built when AOI5_GOLDEN_EN is defined. Rev 1.0
`default_nettype none

module aoi5_sweep_ctrl
  import aoi5_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             fu_out,
  output logic [VEC_W-1:0] vec,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      tt,
  output logic [5:0]       ones_cnt,
  output logic             err,
  output logic [5:0]       mism_cnt
);

  state_t state_q, state_d;
  logic   load, clear, capture, advance, expired;

  aoi5_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .en      (state_q == ST_DRIVE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // abort beats a same-cycle capture, so capture is only raised when abort is low
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d = ST_DRIVE;
          clear   = 1'b1;
          load    = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (abort)        state_d = ST_IDLE;
        else if (expired) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          capture = 1'b1;
          if (vec == VEC_W'(NUM_VEC - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
            advance = 1'b1;
            load    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      tt        <= '0;
      ones_cnt  <= '0;
      busy      <= 1'b0;
      vec_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy      <= (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
      vec_valid <= (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
      done      <= (state_d == ST_DONE);
      if (clear) begin
        vec      <= '0;
        tt       <= '0;
        ones_cnt <= '0;
      end
      if (capture) begin
        tt[vec]  <= fu_out;
        ones_cnt <= ones_cnt + {5'd0, fu_out};
      end
      if (advance) vec <= vec + VEC_W'(1);
    end
  end

`ifdef AOI5_GOLDEN_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mism_cnt <= '0;
      err      <= 1'b0;
    end else if (capture && (fu_out != aoi5_ref(vec))) begin
      mism_cnt <= mism_cnt + 6'd1;
      err      <= 1'b1;
    end
  end
`else
  assign mism_cnt = '0;
  assign err      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aoi5_sweep_ctrl.sv
// tb_aoi5_sweep_ctrl: directed checks of the AOI5 sweep controller at SETTLE=1 and SETTLE=3.
`default_nettype none

module tb_aoi5_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, stuck, fu_out;
  logic [4:0]  vec;
  logic        vec_valid, busy, done, err;
  logic [31:0] tt;
  logic [5:0]  ones_cnt, mism_cnt;

  logic        start3, abort3, fu_out3;
  logic [4:0]  vec3;
  logic        vec_valid3, busy3, done3, err3;
  logic [31:0] tt3;
  logic [5:0]  ones_cnt3, mism_cnt3;

  int n_chk = 0;
  int n_err = 0;

`ifdef AOI5_GOLDEN_EN
  localparam int STUCK_MISM = 17;
  localparam int STUCK_ERR  = 1;
`else
  localparam int STUCK_MISM = 0;
  localparam int STUCK_ERR  = 0;
`endif

  // behavioural stand-in for the external function unit
  function automatic logic fu_model(input logic [4:0] v);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    return ~((a | ~b) & ((c & d) | e));
  endfunction

  assign fu_out  = stuck ? 1'b0 : fu_model(vec);
  assign fu_out3 = fu_model(vec3);

  aoi5_sweep_ctrl #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fu_out(fu_out),
    .vec(vec), .vec_valid(vec_valid), .busy(busy), .done(done),
    .tt(tt), .ones_cnt(ones_cnt), .err(err), .mism_cnt(mism_cnt)
  );

  aoi5_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .fu_out(fu_out3),
    .vec(vec3), .vec_valid(vec_valid3), .busy(busy3), .done(done3),
    .tt(tt3), .ones_cnt(ones_cnt3), .err(err3), .mism_cnt(mism_cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // returns cycles from the accepting edge to the first cycle with done high
  task automatic run_to_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_vec(input logic [4:0] v);
    int n;
    n = 0;
    while (!(busy && vec == v) && n < 400) begin
      tick();
      n++;
    end
    chk("wait_vec", {31'd0, n < 400}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vec"},  {27'd0, vec}, 32'd0);
    chk({tag, "_tt"},   tt, 32'd0);
    chk({tag, "_ones"}, {26'd0, ones_cnt}, 32'd0);
    chk({tag, "_mism"}, {26'd0, mism_cnt}, 32'd0);
    chk({tag, "_ctl"},  {28'd0, err, vec_valid, busy, done}, 32'd0);
  endtask

  initial begin
    int cyc, last, bad;
    logic [4:0] prev;

    rst = 1'b1; start = 1'b0; abort = 1'b0; stuck = 1'b0;
    start3 = 1'b0; abort3 = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // full sweep, correct unit, SETTLE=1
    pulse_start();
    chk("first_drive", {26'd0, busy, vec_valid, vec}, {26'd0, 2'b11, 5'd0});
    run_to_done(cyc);
    chk("latency_s1", cyc, 32'd65);
    chk("tt_good", tt, 32'h1515FF15);
    chk("ones_good", {26'd0, ones_cnt}, 32'd17);
    chk("gold_good", {25'd0, err, mism_cnt}, 32'd0);
    tick(); tick();
    chk("done_hold", {29'd0, done, busy, vec_valid}, 32'b100);

    // stuck-at-0 unit, restarted from DONE
    stuck = 1'b1;
    pulse_start();
    chk("restart_clear", tt, 32'd0);
    run_to_done(cyc);
    chk("latency_restart", cyc, 32'd65);
    chk("tt_stuck", tt, 32'd0);
    chk("ones_stuck", {26'd0, ones_cnt}, 32'd0);
    chk("mism_stuck", {26'd0, mism_cnt}, STUCK_MISM);
    chk("err_stuck", {31'd0, err}, STUCK_ERR);
    stuck = 1'b0;

    // abort during vector 10 DRIVE: vectors 0..9 kept, vector 10 not captured
    pulse_start();
    wait_vec(5'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ctl", {29'd0, done, busy, vec_valid}, 32'd0);
    chk("abort_tt", tt, 32'h00000315);
    chk("abort_ones", {26'd0, ones_cnt}, 32'd5);
    tick();
    chk("abort_idle", {30'd0, done, busy}, 32'd0);

    // abort together with start in IDLE keeps IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", {30'd0, busy, done}, 32'd0);
    chk("start_abort_tt", tt, 32'h00000315);

    // synchronous reset mid-sweep, then a clean sweep
    pulse_start();
    wait_vec(5'd20);
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    tick();
    pulse_start();
    run_to_done(cyc);
    chk("latency_postrst", cyc, 32'd65);
    chk("tt_postrst", tt, 32'h1515FF15);

    // start held high: one sweep, then immediate cleared restart
    start = 1'b1;
    tick();
    run_to_done(cyc);
    chk("latency_held", cyc, 32'd65);
    tick();
    chk("held_restart_ctl", {29'd0, done, busy, vec_valid}, 32'b011);
    chk("held_restart_res", {ones_cnt, tt[25:0]}, 32'd0);
    chk("held_restart_vec", {27'd0, vec}, 32'd0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("held_abort", {31'd0, busy}, 32'd0);

    // SETTLE=3: vec advances every 4 cycles, done at 129
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 1; last = 1; bad = 0; prev = vec3;
    while (!done3 && cyc < 1000) begin
      tick();
      cyc++;
      if (vec3 != prev) begin
        if (cyc - last != 4) bad++;
        last = cyc;
        prev = vec3;
      end
    end
    chk("latency_s3", cyc, 32'd129);
    chk("vec_period_s3", bad, 32'd0);
    chk("tt_s3", tt3, 32'h1515FF15);
    chk("ones_s3", {26'd0, ones_cnt3}, 32'd17);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
